// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU controller for the EX stage.
// A 32-step restoring divider works on unsigned magnitudes; the signs are
// re-applied when the result is written to hi/lo. The pipeline is stalled
// while a divide is in flight, and the divide can be annulled by flush.
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [31:0] rem;      // partial remainder
  logic [31:0] quo;      // dividend magnitude shifting out, quotient shifting in
  logic [31:0] dvsr;     // divisor magnitude
  logic [31:0] a_hold;   // raw dividend, returned as hi on divide-by-zero
  logic        neg_q;
  logic        neg_r;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] sh;
  logic        take;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes and one restoring shift-subtract step.
  // The shifted remainder is 33 bits wide; its top bit is rem[31], so the
  // compare folds that bit in and the subtraction stays 32 bits (the true
  // difference is always below the divisor).
  always_comb begin
    mag_a   = (signed_div && a[31]) ? -a : a;
    mag_b   = (signed_div && b[31]) ? -b : b;
    sh      = {rem[30:0], quo[31]};
    take    = rem[31] || (sh >= dvsr);
    rem_nxt = take ? (sh - dvsr) : sh;
    quo_nxt = {quo[30:0], take};
    q_fix   = neg_q ? -quo_nxt : quo_nxt;
    r_fix   = neg_r ? -rem_nxt : rem_nxt;
  end

  // Pipeline freeze: held while a divide is being accepted or is running.
  always_comb begin
    stall = 1'b0;
    if (resetn && !flush) begin
      stall = (state == IDLE && start) || (state == BUSY) || (state == ZERO);
    end
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      count        <= '0;
      hi           <= '0;
      lo           <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem    <= '0;
            quo    <= mag_a;
            dvsr   <= mag_b;
            a_hold <= a;
            neg_q  <= signed_div && (a[31] ^ b[31]);
            neg_r  <= signed_div && a[31];
            count  <= '0;
            state  <= (b == '0) ? ZERO : BUSY;
          end
        end
        ZERO: begin
          lo           <= '1;
          hi           <= a_hold;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        BUSY: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            lo           <= q_fix;
            hi           <= r_fix;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized checks of div_ctrl against an
// arithmetic reference model of DIV/DIVU results and timing.
module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .a            (a),
    .b            (b),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics using wide signed arithmetic.
  function automatic void model(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (bv == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = av;
    end else if (sgn) begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
    end else begin
      q = av / bv;
      r = av % bv;
    end
  endfunction

  // One divide: start in cycle N, scramble operands mid-divide, expect the
  // result pulse at N+33 (or N+2 for b==0) with stall high until then.
  task automatic run_div(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                         input string tag, input bit idle_after);
    logic [31:0] eq, er;
    int          lat;
    bit          stall_ok;
    model(sgn, av, bv, eq, er);
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; a = av; b = bv;
    @(negedge clk);
    check({tag, "_stall_n"}, {31'd0, stall}, 32'd1);
    lat = 0;
    stall_ok = 1'b1;
    while (!result_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      a = $urandom; b = $urandom; signed_div = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!result_valid && !stall) stall_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), (bv == 32'd0) ? 32'd2 : 32'd33);
    check({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    check({tag, "_lo"}, lo, eq);
    check({tag, "_hi"}, hi, er);
    last_lo = eq;
    last_hi = er;
    if (idle_after) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, result_valid}, 32'd0);
    end
  endtask

  // Watch for any result pulse over a window; hi/lo must keep their value.
  task automatic quiet_window(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    check({tag, "_no_valid"}, {31'd0, seen}, 32'd0);
    check({tag, "_hi_kept"}, hi, last_hi);
    check({tag, "_lo_kept"}, lo, last_lo);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] av, bv;
    int          sel;

    // Reset with start and flush asserted: reset wins, stall stays low.
    resetn = 1'b0; start = 1'b1; flush = 1'b1; signed_div = 1'b0;
    a = 32'd5; b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; start = 1'b0; flush = 1'b0;

    // Directed cases.
    run_div(1'b0, 32'd100, 32'd7, "divu_100_7", 1'b1);
    run_div(1'b1, -32'sd7, 32'd2, "div_m7_2", 1'b1);
    run_div(1'b1, 32'd7, -32'sd2, "div_7_m2", 1'b1);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 1'b1);
    run_div(1'b0, 32'd5, 32'd0, "divu_5_0", 1'b1);
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, "div_neg_0", 0);
    // Back-to-back: start is high in the cycle right after DONE.
    run_div(1'b0, 32'd1234567, 32'd89, "b2b", 1'b1);

    // start and flush together in IDLE: flush wins, nothing starts.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; a = 32'd50; b = 32'd5;
    @(negedge clk);
    check("sf_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("sf_stall_next", {31'd0, stall}, 32'd0);
    quiet_window("sf");

    // Flush at N+10 of a running divide.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("fl_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("fl_idle_stall", {31'd0, stall}, 32'd0);
    quiet_window("fl");
    run_div(1'b0, 32'd1000, 32'd3, "after_flush", 1'b1);

    // Reset at N+20 of a running divide.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b1; a = 32'd77777; b = 32'd13;
    repeat (20) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(negedge clk);
    check("mr_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; start = 1'b0;
    @(negedge clk);
    check("mr_hi", hi, 32'd0);
    check("mr_lo", lo, 32'd0);
    check("mr_valid", {31'd0, result_valid}, 32'd0);
    last_hi = '0;
    last_lo = '0;
    quiet_window("mr");
    run_div(1'b0, 32'd9, 32'd3, "divu_9_3", 1'b1);

    // Randomized divides, including corner divisors and the INT_MIN dividend.
    for (int i = 0; i < 20; i++) begin
      sgn = 1'($urandom_range(0, 1));
      av  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       bv = 32'd0;
        1:       bv = 32'hFFFF_FFFF;
        2:       bv = $urandom_range(1, 16);
        3:       bv = -($urandom_range(1, 16));
        default: bv = $urandom;
      endcase
      run_div(sgn, av, bv, "rand", (i % 2) == 0);
    end

    @(posedge clk); #1;
    start = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
